// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and op classification shared by the ALU/MDU
package alu_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } alu_state_e;

  // Ops handled by the multi-cycle mul/div datapath
  function automatic logic is_iterative(input logic [OP_W-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Multiply family (shift-add); the rest of the iterative ops divide
  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// rtl/alu_mdu_iter.sv - radix-2 iterative multiply/divide datapath, WIDTH steps per op
module alu_mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // p holds {hi, lo}: {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] p_q, p_d, p_step, full;
  logic [WIDTH-1:0]   m_q, m_d, quo, rem_mag;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               busy_q, busy_d, sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [WIDTH:0]     sum, shifted, diff;
  logic               sa_in, sb_in;
  logic [WIDTH-1:0]   ma_in, mb_in;

  // Operand signs and magnitudes at load time
  always_comb begin
    sa_in = (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[WIDTH-1];
    sb_in = (op inside {OP_MULH, OP_DIV, OP_REM}) && b[WIDTH-1];
    ma_in = sa_in ? -a : a;
    mb_in = sb_in ? -b : b;
  end

  // One shift-add or restoring shift-subtract step on the current p
  always_comb begin
    sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    shifted = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    diff    = shifted - {1'b0, m_q};
    if (is_mul(op_q)) begin
      p_step = {sum, p_q[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      p_step = {shifted[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
    end else begin
      p_step = {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up on the final step so the result is ready on the last edge
  always_comb begin
    full    = (sa_q ^ sb_q) ? -p_step : p_step;
    quo     = p_step[WIDTH-1:0];
    rem_mag = p_step[2*WIDTH-1:WIDTH];
    res     = '0;
    case (op_q)
      OP_MUL:                        res = full[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  res = full[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               res = bz_q ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
      OP_REM, OP_REMU:               res = sa_q ? -rem_mag : rem_mag;
      default:                       res = '0;
    endcase
  end

  // Load on start, step while busy, drop out after the last step or on flush
  always_comb begin
    p_d    = p_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    busy_d = busy_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    bz_d   = bz_q;
    if (start) begin
      op_d   = op;
      sa_d   = sa_in;
      sb_d   = sb_in;
      bz_d   = (b == '0);
      busy_d = 1'b1;
      cnt_d  = '0;
      if (is_mul(op)) begin
        p_d = {{WIDTH{1'b0}}, mb_in};
        m_d = ma_in;
      end else begin
        p_d = {{WIDTH{1'b0}}, ma_in};
        m_d = mb_in;
      end
    end else if (busy_q) begin
      p_d   = p_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
    if (flush) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
      busy_q <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      bz_q   <= 1'b0;
    end else begin
      p_q    <= p_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      busy_q <= busy_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      bz_q   <= bz_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - execute-stage integer ALU with iterative mul/div behind valid/ready
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q;
  logic             in_ready_q, out_valid_q, zero_q;
  logic [WIDTH-1:0] result_q, alu_res, iter_res;
  logic [SHW-1:0]   shamt;
  logic             slt, iter_start, iter_busy, iter_done;

  assign shamt      = src_b[SHW-1:0];
  assign slt        = $signed({src_a[WIDTH-1], src_a}) < $signed({src_b[WIDTH-1], src_b});
  assign iter_start = (state_q == ST_IDLE) && in_valid && !flush && is_iterative(op);

  // Single-cycle ops; undefined codes yield zero
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $signed(src_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .start (iter_start),
    .op    (op[OP_W-1:0]),
    .a     (src_a),
    .b     (src_b),
    .busy  (iter_busy),
    .done  (iter_done),
    .res   (iter_res)
  );

  // Handshake FSM with registered in_ready, out_valid, result and zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_iterative(op)) begin
              state_q <= ST_BUSY;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
            end
          end
        end
        ST_BUSY: begin
          if (iter_busy && iter_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= iter_res;
            zero_q      <= (iter_res == '0);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed vector bench for alu_mdu
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, zero;
  logic [31:0] src_a, src_b, result;
  logic [4:0]  op;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32), .OPW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_a     (src_a),
    .src_b     (src_b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one op, measure edges to out_valid, compare result/zero, then release DONE
  task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e, input int lat);
    int edges;
    @(negedge clk);
    check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, " latency"}, edges, lat);
    check({name, " result"}, result, e);
    check({name, " zero"}, {31'b0, zero}, {31'b0, (e == 32'd0)});
    @(posedge clk); #1;
    check({name, " out_valid_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src_a = '0; src_b = '0; op = '0;

    add_vec(OP_ADD,    32'd7,        32'd5,        32'd12,       1);
    add_vec(OP_SUB,    32'd5,        32'd5,        32'd0,        1);
    add_vec(OP_AND,    32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1);
    add_vec(OP_OR,     32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1);
    add_vec(OP_XOR,    32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1);
    add_vec(OP_SLT,    32'hFFFFFFFF, 32'd1,        32'd1,        1);
    add_vec(OP_SLTU,   32'hFFFFFFFF, 32'd1,        32'd0,        1);
    add_vec(OP_SLT,    32'h7FFFFFFF, 32'h80000000, 32'd0,        1);
    add_vec(OP_SLT,    32'h80000000, 32'h7FFFFFFF, 32'd1,        1);
    add_vec(OP_SRA,    32'h80000000, 32'd31,       32'hFFFFFFFF, 1);
    add_vec(OP_SLL,    32'd1,        32'd36,       32'h00000010, 1);
    add_vec(OP_SRL,    32'h80000000, 32'd4,        32'h08000000, 1);
    add_vec(5'd31,     32'd3,        32'd4,        32'd0,        1);
    add_vec(5'd12,     32'd3,        32'd4,        32'd0,        1);
    add_vec(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    add_vec(OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 33);
    add_vec(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    add_vec(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    add_vec(OP_MUL,    32'd6,        32'd7,        32'd42,       33);
    add_vec(OP_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33);
    add_vec(OP_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33);
    add_vec(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    add_vec(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    add_vec(OP_DIVU,   32'd7,        32'd0,        32'hFFFFFFFF, 33);
    add_vec(OP_REMU,   32'd7,        32'd0,        32'd7,        33);
    add_vec(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    add_vec(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    add_vec(OP_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 33);
    add_vec(OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 33);
    add_vec(OP_DIVU,   32'd100,      32'd7,        32'd14,       33);
    add_vec(OP_REMU,   32'd100,      32'd7,        32'd2,        33);

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  {31'b0, in_ready},  32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result",    result,             32'd0);
    check("reset zero",      {31'b0, zero},      32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: hold DONE for 5 cycles, then release and issue another op
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = OP_ADD; src_a = 32'd2; src_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp first valid", {31'b0, out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold result %0d", k), result, 32'd5);
      check($sformatf("bp hold in_ready %0d", k), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp hold valid %0d", k), {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release valid", {31'b0, out_valid}, 32'd0);
    check("bp release in_ready", {31'b0, in_ready}, 32'd1);
    run_op("bp next", OP_ADD, 32'd10, 32'd10, 32'd20, 1);

    // Flush at BUSY cycle 10
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", {31'b0, in_ready}, 32'd1);
    check("flush out_valid", {31'b0, out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush never valid", seen, 32'd0);

    // Flush together with in_valid: nothing accepted
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; src_a = 32'd1; src_b = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush+valid in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("flush+valid out_valid", {31'b0, out_valid}, 32'd0);
    run_op("post flush divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async reset in_ready",  {31'b0, in_ready},  32'd1);
    check("async reset out_valid", {31'b0, out_valid}, 32'd0);
    check("async reset result",    result,             32'd0);
    check("async reset zero",      {31'b0, zero},      32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_op("after reset add", OP_ADD, 32'd1, 32'd1, 32'd2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
